pipeline_ctrl: RTL
==================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipeline: decides stall, flush and operand-forwarding selects every cycle from stage register-address and control fields. Sits beside the ID/EX boundary. It drives the PC and IF/ID hold enables, the IF/ID and ID/EX bubble/flush controls, and the EX operand-mux selects that feed the ALU alongside the immediate path. It also keeps saturating stall/flush event counters for debug.

## Interface
- LOAD_STALL, 1: bubble cycles inserted per load-use hazard (1..7)
- CNT_W, 32: width of event counters
- cpu_clk  in  1  pipeline clock
- cpu_rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_rs1_re, id_rs2_re  in  1 each  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5 each  source registers held in ID/EX
- ex_rd, ex_we, ex_is_load  in  5/1/1  destination, write-enable, load flag in ID/EX
- mem_rd, mem_we  in  5/1  EX/MEM destination and write-enable
- wb_rd, wb_we  in  5/1  MEM/WB destination and write-enable
- ex_redirect  in  1  branch taken / jump resolved in EX this cycle
- stall_pc, stall_if_id  out  1 each  hold PC and IF/ID
- flush_if_id, flush_id_ex  out  1 each  load bubble (NOP) into that register
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- FSM states: RUN, STALL. Down-counter `lu_cnt` is 3 bits wide.
- Load-use hazard `lu_hit`:
  - ex_we & ex_is_load & ex_rd≠0, and
  - (id_rs1_re & id_rs1==ex_rd) | (id_rs2_re & id_rs2==ex_rd).
- RUN, lu_hit, no redirect:
  - assert stall_pc, stall_if_id and flush_id_ex this cycle.
  - If LOAD_STALL>1: lu_cnt←LOAD_STALL-2 and go to STALL. Else stay in RUN.
- STALL:
  - assert stall_pc and stall_if_id. flush_id_ex stays 1 so bubbles keep entering EX.
  - If lu_cnt==0, return to RUN next cycle. Else decrement lu_cnt.
- ex_redirect has highest priority in any state:
  - flush_if_id=flush_id_ex=1, stall_pc=stall_if_id=0.
  - state←RUN, lu_cnt←0. The pending stall is abandoned.
- Forwarding is evaluated independently per operand (a uses ex_rs1, b uses ex_rs2):
  - 01 if mem_we & mem_rd≠0 & mem_rd==ex_rsX;
  - else 10 if wb_we & wb_rd≠0 & wb_rd==ex_rsX;
  - else 00.
  - EX/MEM beats MEM/WB. x0 is never forwarded.
- Counters saturate at all-ones and never wrap.
  - stall_cnt increments on every cycle stall_pc=1.
  - flush_cnt increments once per cycle ex_redirect=1.

## Timing
- Stall, flush and forward outputs are combinational from current state plus inputs. Zero-cycle latency to the pipeline registers sampled at the next cpu_clk edge.
- State, lu_cnt and the counters update on the rising edge of cpu_clk.
- A load-use hazard costs exactly LOAD_STALL cycles of stall_pc=1, first cycle included.
- Reset (async assert, sync-released internally):
  - state=RUN, lu_cnt=0, counters=0.
  - While cpu_rst_n=0, all stall/flush outputs are forced 0 and fwd selects are 00.
  - Reset asserted mid-STALL aborts the stall immediately.
- Simultaneous lu_hit and ex_redirect: redirect wins, no stall, stall_cnt unchanged, flush_cnt+1.
- A redirect arriving in the final STALL cycle behaves as a redirect from RUN.

## Structure
- Shared `param.v` holds `define`s for:
  - fwd select encodings (fwd_RF, fwd_MEM, fwd_WB);
  - FSM state encodings (ctl_RUN, ctl_STALL).
- Sub-module `fwd_unit`: combinational, instantiated twice, once per operand. Ports: rs, mem_rd, mem_we, wb_rd, wb_we → sel.
- The top level contains the FSM, lu_cnt and the counters.

## Test plan
- **Load-use, default LOAD_STALL=1.** ex_rd=5, ex_is_load=1, ex_we=1; id_rs1=5, id_rs1_re=1. Expect one cycle of stall_pc=stall_if_id=flush_id_ex=1, then RUN; stall_cnt=1.
- **LOAD_STALL=3, same hazard.** Expect 3 consecutive stall cycles with flush_id_ex=1, then RUN. Redirect on the 2nd cycle ends the stall that cycle, with flush_if_id=1 and flush_cnt=1.
- **Forward priority.** ex_rs1=7, mem_rd=7/mem_we=1, wb_rd=7/wb_we=1 → fwd_a_sel=01. Drop mem_we → 10. ex_rs2=0 with mem_rd=0, mem_we=1 → fwd_b_sel=00.
- **No false stall.** Load to x0, or id_rs2 matches with id_rs2_re=0 → no stall.
- **Collision.** ex_redirect=1 together with lu_hit → flush both registers, stall_pc=0, stall_cnt unchanged.
- **Reset and saturation.**
  - Assert cpu_rst_n=0 asynchronously mid-STALL: outputs 0 immediately and counters 0.
  - With CNT_W=4, 20 redirect cycles leave flush_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  // Controller FSM states
  typedef enum logic {
    CTL_RUN   = 1'b0,
    CTL_STALL = 1'b1
  } ctl_state_e;

  // EX operand-mux select encodings
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  // A producer matches a consumer register only if it writes, is not x0, and the addresses agree
  function automatic logic addr_hit(input logic we, input reg_addr_t rd, input reg_addr_t rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage register/control fields into the controller and hold/flush/forward controls out.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  reg_addr_t  id_rs1;
  reg_addr_t  id_rs2;
  logic       id_rs1_re;
  logic       id_rs2_re;
  reg_addr_t  ex_rs1;
  reg_addr_t  ex_rs2;
  reg_addr_t  ex_rd;
  logic       ex_we;
  logic       ex_is_load;
  reg_addr_t  mem_rd;
  logic       mem_we;
  reg_addr_t  wb_rd;
  logic       wb_we;
  logic       ex_redirect;

  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       flush_id_ex;
  fwd_sel_t   fwd_a_sel;
  fwd_sel_t   fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline datapath side: presents stage fields, consumes controls
  modport master (
    output id_rs1, id_rs2, id_rs1_re, id_rs2_re,
    output ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
    output mem_rd, mem_we, wb_rd, wb_we, ex_redirect,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_rs1_re, id_rs2_re,
    input  ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
    input  mem_rd, mem_we, wb_rd, wb_we, ex_redirect,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Per-operand forwarding select: the youngest in-flight producer (EX/MEM) wins over MEM/WB.
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  reg_addr_t rs,
  input  reg_addr_t mem_rd,
  input  logic      mem_we,
  input  reg_addr_t wb_rd,
  input  logic      wb_we,
  output fwd_sel_t  sel
);

  // Priority select; x0 never matches so it always reads the register file
  always_comb begin
    sel = FWD_RF;
    if (addr_hit(mem_we, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (addr_hit(wb_we, wb_rd, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: load-use stalls, redirect flushes, operand
// forwarding selects and saturating debug event counters.
module pipeline_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst_n,
  pipeline_ctrl_if.slave bus
);
  import pipeline_ctrl_pkg::*;

  // First stall cycle is spent in RUN, so the counter reloads with the remaining cycles minus one
  localparam bit         MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [2:0] LU_RELOAD   = MULTI_STALL ? 3'(LOAD_STALL - 2) : 3'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  logic [1:0] rst_sync;
  logic       run_en;
  ctl_state_e state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic       lu_hit;
  logic       ld_we;
  logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex;
  fwd_sel_t   sel_a, sel_b;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Reset asserts asynchronously and is released on a clock edge two cycles later
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_en = rst_sync[1];

  assign ld_we  = bus.ex_we & bus.ex_is_load;
  assign lu_hit = (bus.id_rs1_re && addr_hit(ld_we, bus.ex_rd, bus.id_rs1)) ||
                  (bus.id_rs2_re && addr_hit(ld_we, bus.ex_rd, bus.id_rs2));

  fwd_unit u_fwd_a (
    .rs     (bus.ex_rs1),
    .mem_rd (bus.mem_rd),
    .mem_we (bus.mem_we),
    .wb_rd  (bus.wb_rd),
    .wb_we  (bus.wb_we),
    .sel    (sel_a)
  );

  fwd_unit u_fwd_b (
    .rs     (bus.ex_rs2),
    .mem_rd (bus.mem_rd),
    .mem_we (bus.mem_we),
    .wb_rd  (bus.wb_rd),
    .wb_we  (bus.wb_we),
    .sel    (sel_b)
  );

  // FSM state and load-use down-counter
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= CTL_RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Next state and stall/flush controls; redirect overrides any pending stall
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (run_en) begin
      if (bus.ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = CTL_RUN;
        lu_cnt_d    = 3'd0;
      end else begin
        case (state_q)
          CTL_RUN: begin
            if (lu_hit) begin
              stall_pc    = 1'b1;
              stall_if_id = 1'b1;
              flush_id_ex = 1'b1;
              if (MULTI_STALL) begin
                lu_cnt_d = LU_RELOAD;
                state_d  = CTL_STALL;
              end
            end
          end
          CTL_STALL: begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (lu_cnt_q == 3'd0) begin
              state_d = CTL_RUN;
            end else begin
              lu_cnt_d = lu_cnt_q - 3'd1;
            end
          end
          default: begin
            state_d  = CTL_RUN;
            lu_cnt_d = 3'd0;
          end
        endcase
      end
    end
  end

  // Saturating debug counters: stall cycles and redirect cycles
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (run_en && bus.ex_redirect) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign bus.stall_pc    = stall_pc;
  assign bus.stall_if_id = stall_if_id;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.fwd_a_sel   = run_en ? sel_a : FWD_RF;
  assign bus.fwd_b_sel   = run_en ? sel_b : FWD_RF;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
